alu_seq: RTL

Parametrised, pipelined successor to the single-cycle combinational ALU in the RV32I core's execute stage. Adds registered outputs, a valid/ready handshake on both sides, signed/unsigned compares, barrel shifts, and iterative unsigned multiply/divide. Execute-stage control stalls on `in_ready`/`out_valid` instead of assuming a fixed one-cycle result.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_muldiv_iter.sv | 74 +++++++
 rtl/alu_seq.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and helpers
// shared by the sequential ALU and its iterative unit
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_XOR   = 4'b0011,
    ALU_SLTU  = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_SLL   = 4'b1000,
    ALU_SRL   = 4'b1001,
    ALU_SRA   = 4'b1010,
    ALU_MUL   = 4'b1100,
    ALU_MULHU = 4'b1101,
    ALU_DIVU  = 4'b1110,
    ALU_REMU  = 4'b1111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  localparam int MAX_W = 128;

  // alternating 01 pattern, low w bits set
  function automatic logic [MAX_W-1:0]
    ILLEGAL_PATTERN(input int w);
    logic [MAX_W-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_W; i++)
      p[i] = (i % 2 == 0) && (i < w);
    return p;
  endfunction

  function automatic logic is_iterative(
    input logic [3:0] op
  );
    return op[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: shift-add multiply and
// restoring divide, one bit per clock
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [SHW-1:0] LAST =
    SHW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] nxt;
  logic [WIDTH-1:0]   opnd;
  logic [1:0]         kind;
  logic [SHW-1:0]     cnt;
  logic               busy;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;

  assign done = busy && (cnt == LAST);

  // one multiply or divide step on the accumulator
  always_comb begin
    addend = acc[0] ? {1'b0, opnd} : '0;
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + addend;
    trial  = acc[2*WIDTH-1:WIDTH-1]
           - {1'b0, opnd};
    nxt    = acc;
    if (!kind[1])
      nxt = {sum, acc[WIDTH-1:1]};
    else if (!trial[WIDTH])
      nxt = {trial[WIDTH-1:0],
             acc[WIDTH-2:0], 1'b1};
    else
      nxt = {acc[2*WIDTH-2:0], 1'b0};
    result = kind[0] ? nxt[2*WIDTH-1:WIDTH]
                     : nxt[WIDTH-1:0];
  end

  // operand capture and iteration state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      opnd <= '0;
      kind <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      acc  <= {{WIDTH{1'b0}},
               op[1] ? a : b};
      opnd <= op[1] ? b : a;
      kind <= op;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc <= nxt;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked pipelined ALU with
// registered result and iterative mul/div
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [MAX_W-1:0] ILL_FULL =
    ILLEGAL_PATTERN(WIDTH);
  localparam logic [WIDTH-1:0] ILL =
    ILL_FULL[WIDTH-1:0];

  alu_state_t       state;
  logic             accept;
  logic             iter_op;
  logic             ill_op;
  logic [WIDTH-1:0] alu_res;
  logic             md_done;
  logic [WIDTH-1:0] md_res;
  logic [SHW-1:0]   sh;

  assign in_ready  = (state == ST_IDLE) ||
                     (state == ST_DONE && out_ready);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign iter_op   = is_iterative(op);
  assign ill_op    = (op == 4'b0111) ||
                     (op == 4'b1011);
  assign sh        = b_in[SHW-1:0];

  // single-cycle datapath
  always_comb begin
    alu_res = ILL;
    unique case (op)
      ALU_ADD:  alu_res = a_in + b_in;
      ALU_SUB:  alu_res = a_in - b_in;
      ALU_AND:  alu_res = a_in & b_in;
      ALU_XOR:  alu_res = a_in ^ b_in;
      ALU_OR:   alu_res = a_in | b_in;
      ALU_SLTU: alu_res =
        WIDTH'(a_in < b_in);
      ALU_SLT:  alu_res =
        WIDTH'($signed(a_in) < $signed(b_in));
      ALU_SLL:  alu_res = a_in << sh;
      ALU_SRL:  alu_res = a_in >> sh;
      ALU_SRA:  alu_res =
        $unsigned($signed(a_in) >>> sh);
      default:  alu_res = ILL;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_md (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && iter_op),
    .op     (op[1:0]),
    .a      (a_in),
    .b      (b_in),
    .done   (md_done),
    .result (md_res)
  );

  // control FSM and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (iter_op) begin
              state <= ST_ITER;
            end else begin
              state   <= ST_DONE;
              result  <= alu_res;
              zero    <= !ill_op &&
                         (alu_res == '0);
              illegal <= ill_op;
            end
          end else if (state == ST_DONE &&
                       out_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_ITER: begin
          if (md_done) begin
            state   <= ST_DONE;
            result  <= md_res;
            zero    <= (md_res == '0);
            illegal <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
